// File: rtl/ysyx_23060236_muldiv_ctrl.sv
// ysyx_23060236_muldiv_ctrl
// Sequencer between the EXU issue point and the shared iterative multiplier
// and divider. Takes one RV32M op per handshake, drives the selected unit,
// holds the result until writeback takes it, and drops results that a
// redirect flush has killed. The unit that owns an op is always f3[2]
// (0 = multiplier, 1 = divider).
//
// Optional feature: define MULDIV_CORNER_BYPASS_EN to answer divide-by-zero
// and signed overflow divisions directly from the request, without starting
// the divider. Without it every division goes through the divider.
module ysyx_23060236_muldiv_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  // request side
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_funct3,
  input  logic [TAG_W-1:0] req_rd,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  input  logic             flush,
  // multiplier
  output logic             mul_valid,
  input  logic             mul_ready,
  output logic [1:0]       mul_sign,
  output logic [XLEN-1:0]  mul1,
  output logic [XLEN-1:0]  mul2,
  input  logic [XLEN-1:0]  mul_high,
  input  logic [XLEN-1:0]  mul_low,
  input  logic             mul_outvalid,
  // divider
  output logic             div_valid,
  input  logic             div_ready,
  output logic             div_sign,
  output logic [XLEN-1:0]  div1,
  output logic [XLEN-1:0]  div2,
  input  logic [XLEN-1:0]  div_res,
  input  logic [XLEN-1:0]  div_rem,
  input  logic             div_outvalid,
  // response side
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [TAG_W-1:0] rsp_rd,
  output logic [XLEN-1:0]  rsp_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DRAIN,
    S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       f3_q, f3_d;
  logic [TAG_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]  src1_q, src1_d;
  logic [XLEN-1:0]  src2_q, src2_d;
  logic [XLEN-1:0]  data_q, data_d;

  logic             is_div;
  logic             unit_ready;
  logic             unit_outvalid;
  logic [XLEN-1:0]  unit_result;

  // Per-op unit selection and result steering, all from the latched funct3.
  assign is_div        = f3_q[2];
  assign unit_ready    = is_div ? div_ready : mul_ready;
  assign unit_outvalid = is_div ? div_outvalid : mul_outvalid;
  assign unit_result   = is_div ? (f3_q[1] ? div_rem : div_res)
                                : ((f3_q[1:0] == 2'b00) ? mul_low : mul_high);

  // Request handshake: only when idle, and never in a cycle being flushed.
  assign req_ready = (state_q == S_IDLE) & ~flush;

  // Unit drive: start request is held through ISSUE until the unit accepts.
  assign mul_valid = (state_q == S_ISSUE) & ~is_div;
  assign div_valid = (state_q == S_ISSUE) &  is_div;
  assign mul1      = src1_q;
  assign mul2      = src2_q;
  assign div1      = src1_q;
  assign div2      = src2_q;
  // mulhu -> both unsigned, mulhsu -> only src1 signed, mul/mulh -> both signed.
  assign mul_sign  = (f3_q[1:0] == 2'b11) ? 2'b00 :
                     (f3_q[1:0] == 2'b10) ? 2'b10 : 2'b11;
  assign div_sign  = ~f3_q[0];

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rd    = rd_q;
  assign rsp_data  = data_q;
  assign busy      = (state_q != S_IDLE);

`ifdef MULDIV_CORNER_BYPASS_EN
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic            corner_zero;
  logic            corner_ovf;
  logic            corner_hit;
  logic [XLEN-1:0] corner_result;

  // Division corners resolved straight from the incoming request operands.
  assign corner_zero   = (req_src2 == '0);
  assign corner_ovf    = ~req_funct3[0] & (req_src1 == INT_MIN) & (req_src2 == '1);
  assign corner_hit    = req_funct3[2] & (corner_zero | corner_ovf);
  assign corner_result = req_funct3[1] ? (corner_zero ? req_src1 : '0)
                                       : (corner_zero ? '1 : INT_MIN);
`endif

  // Next-state and datapath capture logic for the op sequencer.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d = state_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    data_d  = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          f3_d    = req_funct3;
          rd_d    = req_rd;
          src1_d  = req_src1;
          src2_d  = req_src2;
          state_d = S_ISSUE;
`ifdef MULDIV_CORNER_BYPASS_EN
          if (corner_hit) begin
            data_d  = corner_result;
            state_d = S_RESP;
          end
`endif
        end
      end
      S_ISSUE: begin
        // A flush before the unit accepts means nothing was started; a flush
        // on the accept cycle leaves a result in flight that must be drained.
        if (flush) begin
          state_d = unit_ready ? S_DRAIN : S_IDLE;
        end else if (unit_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = unit_outvalid ? S_IDLE : S_DRAIN;
        end else if (unit_outvalid) begin
          data_d  = unit_result;
          state_d = S_RESP;
        end
      end
      S_DRAIN: begin
        if (unit_outvalid) begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (flush || rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and operand/result registers; reset returns everything to zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      rd_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      data_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples its _d value
      // from before this edge, independent of statement order.
      state_q <= state_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_ysyx_23060236_muldiv_ctrl.sv
// Self-checking bench for ysyx_23060236_muldiv_ctrl. A table of RV32M ops
// with hand-derived results is run through behavioural multiplier/divider
// models; expected responses go into a scoreboard queue when the request is
// driven and are compared when the response appears. Hand-written sequences
// cover flush, drain, stall and reset corners.
module tb_ysyx_23060236_muldiv_ctrl;

  localparam int XLEN  = 32;
  localparam int TAG_W = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [2:0]       req_funct3 = '0;
  logic [TAG_W-1:0] req_rd = '0;
  logic [XLEN-1:0]  req_src1 = '0;
  logic [XLEN-1:0]  req_src2 = '0;
  logic             flush = 1'b0;
  logic             mul_valid;
  logic             mul_ready = 1'b0;
  logic [1:0]       mul_sign;
  logic [XLEN-1:0]  mul1, mul2;
  logic [XLEN-1:0]  mul_high = '0;
  logic [XLEN-1:0]  mul_low = '0;
  logic             mul_outvalid = 1'b0;
  logic             div_valid;
  logic             div_ready = 1'b0;
  logic             div_sign;
  logic [XLEN-1:0]  div1, div2;
  logic [XLEN-1:0]  div_res = '0;
  logic [XLEN-1:0]  div_rem = '0;
  logic             div_outvalid = 1'b0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [TAG_W-1:0] rsp_rd;
  logic [XLEN-1:0]  rsp_data;
  logic             busy;

  ysyx_23060236_muldiv_ctrl #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rd(req_rd), .req_src1(req_src1), .req_src2(req_src2), .flush(flush),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_sign(mul_sign),
    .mul1(mul1), .mul2(mul2), .mul_high(mul_high), .mul_low(mul_low),
    .mul_outvalid(mul_outvalid),
    .div_valid(div_valid), .div_ready(div_ready), .div_sign(div_sign),
    .div1(div1), .div2(div2), .div_res(div_res), .div_rem(div_rem),
    .div_outvalid(div_outvalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd),
    .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          rdy_dly;
    int          res_dly;
    int          stall;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } sb_t;

  vec_t vecs[15];
  sb_t  sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] exp_mul_sign(input logic [2:0] f3);
    case (f3[1:0])
      2'b11:   return 2'b00;
      2'b10:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  // Behavioural multiplier: 64-bit product of the operands as the DUT signs them.
  function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] s);
    logic [63:0] ea, eb;
    ea = s[1] ? {{32{a[31]}}, a} : {32'b0, a};
    eb = s[0] ? {{32{b[31]}}, b} : {32'b0, b};
    return ea * eb;
  endfunction

  // Behavioural divider: {quotient, remainder} with RV32M corner results.
  function automatic logic [63:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic bit bypass_expected(input vec_t v);
    bit en;
    bit corner;
`ifdef MULDIV_CORNER_BYPASS_EN
    en = 1'b1;
`else
    en = 1'b0;
`endif
    corner = v.f3[2] && (v.b == 32'd0 ||
             (!v.f3[0] && v.a == 32'h8000_0000 && v.b == 32'hFFFF_FFFF));
    return en && corner;
  endfunction

  // Drive one request through accept; returns #1 after the following negedge.
  task automatic accept(input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    req_valid = 1'b1; req_funct3 = f3; req_rd = rd; req_src1 = a; req_src2 = b;
    #1;
    check("accept_req_ready", 64'(req_ready), 64'd1);
    @(negedge clock);
    req_valid = 1'b0;
    #1;
  endtask

  // Full op from the table, with unit handshake/result delays and rsp stall.
  task automatic do_op(input vec_t v);
    bit          byp;
    logic [63:0] p, qr;
    byp = bypass_expected(v);
    p   = '0;
    qr  = '0;
    @(negedge clock);
    req_valid = 1'b1; req_funct3 = v.f3; req_rd = v.rd; req_src1 = v.a; req_src2 = v.b;
    #1;
    check("req_ready", 64'(req_ready), 64'd1);
    sb.push_back('{rd: v.rd, data: v.exp});
    @(negedge clock);
    req_valid = 1'b0;
    if (!byp) begin
      for (int i = 0; i <= v.rdy_dly; i++) begin
        mul_ready = (i == v.rdy_dly) && !v.f3[2];
        div_ready = (i == v.rdy_dly) &&  v.f3[2];
        #1;
        check("issue_mul_valid", 64'(mul_valid), 64'(!v.f3[2]));
        check("issue_div_valid", 64'(div_valid), 64'(v.f3[2]));
        check("issue_rsp_valid", 64'(rsp_valid), 64'd0);
        if (i == v.rdy_dly) begin
          if (!v.f3[2]) check("mul_sign", 64'(mul_sign), 64'(exp_mul_sign(v.f3)));
          else          check("div_sign", 64'(div_sign), 64'(!v.f3[0]));
          p  = mul_model(mul1, mul2, mul_sign);
          qr = div_model(div1, div2, div_sign);
        end
        @(negedge clock);
      end
      mul_ready = 1'b0; div_ready = 1'b0;
      for (int i = 0; i <= v.res_dly; i++) begin
        mul_outvalid = (i == v.res_dly) && !v.f3[2];
        div_outvalid = (i == v.res_dly) &&  v.f3[2];
        mul_high = p[63:32]; mul_low = p[31:0];
        div_res  = qr[63:32]; div_rem = qr[31:0];
        #1;
        check("wait_start_low", 64'({mul_valid, div_valid}), 64'd0);
        check("wait_rsp_valid", 64'(rsp_valid), 64'd0);
        check("wait_busy", 64'(busy), 64'd1);
        @(negedge clock);
      end
      mul_outvalid = 1'b0; div_outvalid = 1'b0;
      mul_high = '0; mul_low = '0; div_res = '0; div_rem = '0;
    end
    for (int i = 0; i <= v.stall; i++) begin
      rsp_ready = (i == v.stall);
      #1;
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      check("rsp_rd", 64'(rsp_rd), 64'(sb[0].rd));
      check("rsp_data", 64'(rsp_data), 64'(sb[0].data));
      check("resp_start_low", 64'({mul_valid, div_valid}), 64'd0);
      check("resp_req_ready", 64'(req_ready), 64'd0);
      if (i == v.stall) void'(sb.pop_front());
      @(negedge clock);
    end
    rsp_ready = 1'b0;
    #1;
    check("post_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 5'd1,  32'd3,          32'hFFFF_FFFB, 32'hFFFF_FFF1, 0, 0, 0};
    vecs[1]  = '{3'b011, 5'd2,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0, 4};
    vecs[2]  = '{3'b100, 5'd3,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0, 0, 0};
    vecs[3]  = '{3'b110, 5'd4,  32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1, 0, 0};
    vecs[4]  = '{3'b101, 5'd5,  32'd7,          32'd2,         32'd3,         0, 1, 0};
    vecs[5]  = '{3'b001, 5'd6,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         2, 3, 1};
    vecs[6]  = '{3'b010, 5'd7,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 2, 0};
    vecs[7]  = '{3'b111, 5'd8,  32'd100,        32'd7,         32'd2,         1, 2, 2};
    vecs[8]  = '{3'b100, 5'd9,  32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0, 0, 0};
    vecs[9]  = '{3'b110, 5'd10, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0, 0, 0};
    vecs[10] = '{3'b101, 5'd11, 32'd5,          32'd0,         32'hFFFF_FFFF, 0, 0, 0};
    vecs[11] = '{3'b111, 5'd12, 32'h1234,       32'd0,         32'h1234,      0, 0, 1};
    vecs[12] = '{3'b100, 5'd13, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 0, 0, 0};
    vecs[13] = '{3'b000, 5'd31, 32'h0001_0000,  32'h0001_0000, 32'd0,         0, 0, 0};
    vecs[14] = '{3'b011, 5'd0,  32'h0001_0000,  32'h0001_0000, 32'd1,         0, 0, 0};

    // Reset state.
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valids", 64'({mul_valid, div_valid, rsp_valid}), 64'd0);
    check("rst_rsp_data", 64'(rsp_data), 64'd0);
    check("rst_rsp_rd", 64'(rsp_rd), 64'd0);
    check("rst_operands", 64'({mul1, div2}), 64'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    // Flush masks req_ready while idle.
    @(negedge clock);
    flush = 1'b1;
    #1;
    check("idle_flush_req_ready", 64'(req_ready), 64'd0);
    flush = 1'b0;

    foreach (vecs[i]) do_op(vecs[i]);

    // Flush in ISSUE before the unit accepts: back to idle, nothing started.
    accept(3'b000, 5'd14, 32'd2, 32'd3);
    flush = 1'b1; mul_ready = 1'b0;
    @(negedge clock);
    flush = 1'b0;
    #1;
    check("fi_busy", 64'(busy), 64'd0);
    check("fi_mul_valid", 64'(mul_valid), 64'd0);
    check("fi_req_ready", 64'(req_ready), 64'd1);

    // Flush on the ISSUE handshake: drain the in-flight product.
    accept(3'b000, 5'd15, 32'd2, 32'd3);
    flush = 1'b1; mul_ready = 1'b1;
    @(negedge clock);
    flush = 1'b0; mul_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("fh_drain_busy", 64'(busy), 64'd1);
      check("fh_drain_req_ready", 64'(req_ready), 64'd0);
      check("fh_drain_start_low", 64'({mul_valid, rsp_valid}), 64'd0);
      @(negedge clock);
    end
    mul_outvalid = 1'b1; mul_low = 32'd6;
    @(negedge clock);
    mul_outvalid = 1'b0; mul_low = '0;
    #1;
    check("fh_idle_busy", 64'(busy), 64'd0);
    check("fh_idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // Flush in WAIT on a divide: no response, busy until the divider answers.
    accept(3'b100, 5'd16, 32'hFFFF_FFF9, 32'd2);
    div_ready = 1'b1;
    @(negedge clock);
    div_ready = 1'b0; flush = 1'b1;
    @(negedge clock);
    flush = 1'b0; req_valid = 1'b1; req_funct3 = 3'b000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fw_busy", 64'(busy), 64'd1);
      check("fw_req_ready", 64'(req_ready), 64'd0);
      check("fw_rsp_valid", 64'(rsp_valid), 64'd0);
      @(negedge clock);
    end
    req_valid = 1'b0; div_outvalid = 1'b1; div_res = 32'hFFFF_FFFD;
    #1;
    check("fw_last_drain_busy", 64'(busy), 64'd1);
    @(negedge clock);
    div_outvalid = 1'b0; div_res = '0;
    #1;
    check("fw_idle_busy", 64'(busy), 64'd0);
    check("fw_idle_req_ready", 64'(req_ready), 64'd1);
    check("fw_idle_rsp_valid", 64'(rsp_valid), 64'd0);

    // Flush and outvalid together in WAIT: result dropped, straight to idle.
    accept(3'b000, 5'd17, 32'd2, 32'd3);
    mul_ready = 1'b1;
    @(negedge clock);
    mul_ready = 1'b0; flush = 1'b1; mul_outvalid = 1'b1; mul_low = 32'd6;
    @(negedge clock);
    flush = 1'b0; mul_outvalid = 1'b0; mul_low = '0;
    #1;
    check("fo_busy", 64'(busy), 64'd0);
    check("fo_rsp_valid", 64'(rsp_valid), 64'd0);

    // Flush in RESP beats rsp_ready.
    accept(3'b000, 5'd18, 32'd2, 32'd3);
    mul_ready = 1'b1;
    @(negedge clock);
    mul_ready = 1'b0; mul_outvalid = 1'b1; mul_low = 32'd6;
    @(negedge clock);
    mul_outvalid = 1'b0; mul_low = '0;
    #1;
    check("fr_rsp_valid", 64'(rsp_valid), 64'd1);
    check("fr_rsp_data", 64'(rsp_data), 64'd6);
    check("fr_rsp_rd", 64'(rsp_rd), 64'd18);
    flush = 1'b1; rsp_ready = 1'b1;
    @(negedge clock);
    flush = 1'b0; rsp_ready = 1'b0;
    #1;
    check("fr_after_rsp_valid", 64'(rsp_valid), 64'd0);
    check("fr_after_busy", 64'(busy), 64'd0);

    // Stray outvalid pulses while idle are ignored.
    @(negedge clock);
    mul_outvalid = 1'b1; div_outvalid = 1'b1;
    @(negedge clock);
    mul_outvalid = 1'b0; div_outvalid = 1'b0;
    #1;
    check("stray_busy", 64'(busy), 64'd0);
    check("stray_rsp_valid", 64'(rsp_valid), 64'd0);

    // Reset asserted while waiting on the divider.
    accept(3'b100, 5'd19, 32'd100, 32'd7);
    div_ready = 1'b1;
    @(negedge clock);
    div_ready = 1'b0;
    #1;
    check("mr_in_wait_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    check("mr_busy", 64'(busy), 64'd0);
    check("mr_valids", 64'({mul_valid, div_valid, rsp_valid}), 64'd0);
    check("mr_rsp_data", 64'(rsp_data), 64'd0);
    check("mr_rsp_rd", 64'(rsp_rd), 64'd0);
    check("mr_div1", 64'(div1), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Normal op after the mid-op reset.
    do_op(vecs[0]);

    check("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
